// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Default parameter values and the matching widths live here so every file agrees on them.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_MAX_BURST = 4;
    localparam int PTR_W         = (DEF_NREQ > 1) ? $clog2(DEF_NREQ) : 1;
    localparam int BCNT_W        = $clog2(DEF_MAX_BURST + 1);

    // Width helpers for non-default parameterisations.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bcnt_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after start (wrapping),
// skipping any requester set in excl.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = DEF_NREQ,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  gnt,
    output logic          found
);

    logic [N-1:0] cand;

    assign cand = req & ~excl;

    always_comb begin
        int idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(start) + i) % N;
            if (!found && cand[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, bursts of up to MAX_BURST beats.
// Optional per-requester accepted-beat counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  res_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ-1:0]       req_last_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_wr_en_o,
    output logic [WIDTH-1:0]      fifo_wdata_o,
    output logic [NREQ-1:0]       grant_o,
    output logic                  busy_o
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                  stat_clr_i,
    output logic [NREQ*CNT_WIDTH-1:0] stat_cnt_o
`endif
);

    localparam int PW = ptr_width(NREQ);
    localparam int BW = bcnt_width(MAX_BURST);

    arb_state_t      state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;

    logic [PW-1:0]   g_idx, g_succ, pick_start;
    logic [NREQ-1:0] pick_excl, pick_gnt;
    logic            pick_found;
    logic            in_grant, g_valid, g_last, accept, burst_end;
    logic [WIDTH-1:0] masked_data [NREQ];

    always_comb begin
        g_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_reg[k]) g_idx = PW'(k);
        end
    end

    assign g_succ    = (int'(g_idx) == NREQ - 1) ? '0 : g_idx + 1'b1;
    assign in_grant  = (state_reg == GRANT);
    assign g_valid   = |(req_valid_i & grant_reg);
    assign g_last    = |(req_last_i & grant_reg);
    assign accept    = in_grant & g_valid & ~fifo_full_i;
    // A dropped valid ends the burst even while the FIFO is full.
    assign burst_end = in_grant & (~g_valid |
                       (accept & (g_last | (beat_cnt_reg == BW'(MAX_BURST - 1)))));

    // At burst end the search starts after the current owner and skips it.
    assign pick_start = in_grant ? g_succ : rr_ptr_reg;
    assign pick_excl  = in_grant ? grant_reg : '0;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req   (req_valid_i),
        .start (pick_start),
        .excl  (pick_excl),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_gnt;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (burst_end) begin
                    rr_ptr_next   = g_succ;
                    beat_cnt_next = '0;
                    if (pick_found) begin
                        grant_next = pick_gnt;
                    end else begin
                        grant_next = '0;
                        state_next = IDLE;
                    end
                end else if (accept && beat_cnt_reg != BW'(MAX_BURST)) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign masked_data[gi] = {WIDTH{grant_reg[gi]}} & req_data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        fifo_wdata_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            fifo_wdata_o = fifo_wdata_o | masked_data[k];
        end
    end

    assign fifo_wr_en_o = accept;
    assign req_ready_o  = accept ? grant_reg : '0;
    assign grant_o      = grant_reg;
    assign busy_o       = in_grant;

`ifdef FIFO_ARB_STATS_EN
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stat
            logic [CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge clk_i or posedge res_i) begin
                if (res_i) begin
                    cnt_reg <= '0;
                end else if (stat_clr_i) begin
                    cnt_reg <= '0;
                end else if (req_ready_o[gi] && cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign stat_cnt_o[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, WIDTH=8, MAX_BURST=4).
// The statistics step is compiled only when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

    logic        clk_i;
    logic        res_i;
    logic [3:0]  req_valid_i;
    logic [3:0]  req_last_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_ready_o;
    logic        fifo_full_i;
    logic        fifo_wr_en_o;
    logic [7:0]  fifo_wdata_o;
    logic [3:0]  grant_o;
    logic        busy_o;
`ifdef FIFO_ARB_STATS_EN
    logic        stat_clr_i;
    logic [63:0] stat_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(
        .NREQ      (4),
        .WIDTH     (8),
        .MAX_BURST (4),
        .CNT_WIDTH (16)
    ) dut (
        .clk_i        (clk_i),
        .res_i        (res_i),
        .req_valid_i  (req_valid_i),
        .req_last_i   (req_last_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_wdata_o (fifo_wdata_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_clr_i   (stat_clr_i),
        .stat_cnt_o   (stat_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef FIFO_ARB_STATS_EN
        int acc;
        int cyc;
        stat_clr_i = 1'b0;
`endif
        res_i       = 1'b1;
        req_valid_i = 4'b1111;
        req_last_i  = 4'b0000;
        fifo_full_i = 1'b0;
        req_data_i  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_grant", 64'(grant_o), 64'h0);
        chk("rst_wr_en", 64'(fifo_wr_en_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_ready", 64'(req_ready_o), 64'h0);
        chk("rst_wdata", 64'(fifo_wdata_o), 64'h0);

        // 1: all valid, four-beat bursts rotate 0,1,2,3 with no idle cycle
        res_i = 1'b0;
        #1;
        chk("t1_idle_grant", 64'(grant_o), 64'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 4; b++) begin
                chk($sformatf("t1_grant_r%0d_b%0d", k, b), 64'(grant_o), 64'(1) << k);
                chk($sformatf("t1_ready_r%0d_b%0d", k, b), 64'(req_ready_o), 64'(1) << k);
                chk($sformatf("t1_wdata_r%0d_b%0d", k, b), 64'(fifo_wdata_o), 64'hA0 + 64'(k));
                tick();
            end
        end
        chk("t1_wrap_grant", 64'(grant_o), 64'h1);
        req_valid_i = 4'b0000;
        #1;
        chk("t1_abandon_wr_en", 64'(fifo_wr_en_o), 64'h0);
        tick();
        chk("t1_idle_after", 64'(grant_o), 64'h0);

        // 2: req2 alone, 10 beats -> 4, idle, 4, idle, 2
        req_valid_i = 4'b0100;
        #1;
        tick();
        for (int rep = 0; rep < 3; rep++) begin
            for (int b = 0; b < ((rep == 2) ? 2 : 4); b++) begin
                chk($sformatf("t2_grant_g%0d_b%0d", rep, b), 64'(grant_o), 64'h4);
                chk($sformatf("t2_wr_en_g%0d_b%0d", rep, b), 64'(fifo_wr_en_o), 64'h1);
                chk($sformatf("t2_wdata_g%0d_b%0d", rep, b), 64'(fifo_wdata_o), 64'hA2);
                tick();
            end
            if (rep < 2) begin
                chk($sformatf("t2_bubble_grant_%0d", rep), 64'(grant_o), 64'h0);
                chk($sformatf("t2_bubble_busy_%0d", rep), 64'(busy_o), 64'h0);
                chk($sformatf("t2_bubble_wr_en_%0d", rep), 64'(fifo_wr_en_o), 64'h0);
                tick();
            end
        end
        req_valid_i = 4'b0000;
        #1;
        chk("t2_drop_grant", 64'(grant_o), 64'h4);
        chk("t2_drop_wr_en", 64'(fifo_wr_en_o), 64'h0);
        tick();
        chk("t2_end_grant", 64'(grant_o), 64'h0);

        // 3: req0+req1, FIFO full for 3 cycles after two beats
        req_valid_i = 4'b0011;
        #1;
        tick();
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("t3_pre_grant_b%0d", b), 64'(grant_o), 64'h1);
            chk($sformatf("t3_pre_wr_en_b%0d", b), 64'(fifo_wr_en_o), 64'h1);
            tick();
        end
        fifo_full_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_full_wr_en_%0d", i), 64'(fifo_wr_en_o), 64'h0);
            chk($sformatf("t3_full_ready_%0d", i), 64'(req_ready_o), 64'h0);
            chk($sformatf("t3_full_grant_%0d", i), 64'(grant_o), 64'h1);
            chk($sformatf("t3_full_busy_%0d", i), 64'(busy_o), 64'h1);
            tick();
        end
        fifo_full_i = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("t3_post_grant_b%0d", b), 64'(grant_o), 64'h1);
            chk($sformatf("t3_post_wr_en_b%0d", b), 64'(fifo_wr_en_o), 64'h1);
            tick();
        end
        chk("t3_next_grant", 64'(grant_o), 64'h2);
        chk("t3_next_wr_en", 64'(fifo_wr_en_o), 64'h1);
        chk("t3_next_wdata", 64'(fifo_wdata_o), 64'hA1);
        req_valid_i = 4'b0000;
        #1;
        tick();
        chk("t3_end_grant", 64'(grant_o), 64'h0);

        // 4: req1 ends its packet on beat 2, req3 waiting
        req_valid_i = 4'b0010;
        #1;
        tick();
        req_valid_i = 4'b1010;
        #1;
        chk("t4_b0_grant", 64'(grant_o), 64'h2);
        chk("t4_b0_wr_en", 64'(fifo_wr_en_o), 64'h1);
        tick();
        req_last_i = 4'b0010;
        #1;
        chk("t4_b1_grant", 64'(grant_o), 64'h2);
        chk("t4_b1_wr_en", 64'(fifo_wr_en_o), 64'h1);
        tick();
        req_last_i = 4'b0000;
        #1;
        chk("t4_next_grant", 64'(grant_o), 64'h8);
        chk("t4_next_wdata", 64'(fifo_wdata_o), 64'hA3);
        req_valid_i = 4'b0000;
        #1;
        tick();
        chk("t4_end_grant", 64'(grant_o), 64'h0);

        // 5: asynchronous reset in the middle of req3's burst
        req_valid_i = 4'b1100;
        #1;
        tick();
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("t5_r2_grant_b%0d", b), 64'(grant_o), 64'h4);
            tick();
        end
        chk("t5_r3_grant", 64'(grant_o), 64'h8);
        tick();
        #2;
        res_i = 1'b1;
        #1;
        chk("t5_async_grant", 64'(grant_o), 64'h0);
        chk("t5_async_busy", 64'(busy_o), 64'h0);
        chk("t5_async_wr_en", 64'(fifo_wr_en_o), 64'h0);
        req_valid_i = 4'b1111;
        #1;
        res_i = 1'b0;
        tick();
        chk("t5_restart_grant", 64'(grant_o), 64'h1);
        req_valid_i = 4'b0000;
        #1;
        tick();
        chk("t5_end_grant", 64'(grant_o), 64'h0);

`ifdef FIFO_ARB_STATS_EN
        // 6: per-requester beat counters and synchronous clear
        stat_clr_i = 1'b1;
        #1;
        tick();
        stat_clr_i = 1'b0;
        #1;
        chk("t6_clr0", stat_cnt_o, 64'h0);
        req_valid_i = 4'b0001;
        acc = 0;
        cyc = 0;
        while (acc < 5 && cyc < 40) begin
            #1;
            if (req_ready_o[0]) acc++;
            tick();
            cyc++;
        end
        req_valid_i = 4'b0000;
        chk("t6_r0_beats", 64'(acc), 64'd5);
        #1;
        tick();
        req_valid_i = 4'b1000;
        acc = 0;
        cyc = 0;
        while (acc < 3 && cyc < 40) begin
            #1;
            if (req_ready_o[3]) acc++;
            tick();
            cyc++;
        end
        req_valid_i = 4'b0000;
        chk("t6_r3_beats", 64'(acc), 64'd3);
        #1;
        tick();
        chk("t6_stat0", 64'(stat_cnt_o[15:0]), 64'd5);
        chk("t6_stat1", 64'(stat_cnt_o[31:16]), 64'd0);
        chk("t6_stat2", 64'(stat_cnt_o[47:32]), 64'd0);
        chk("t6_stat3", 64'(stat_cnt_o[63:48]), 64'd3);
        stat_clr_i = 1'b1;
        #1;
        tick();
        stat_clr_i = 1'b0;
        #1;
        chk("t6_clr1", stat_cnt_o, 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
